pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, 32, program counter width in bits.
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-003 Parameter INSTR_BYTES, 4, sequential increment in bytes.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 take_branch  input  1  registered-stage branch decision (branch AND zero) from the gating stage.
REQ-007 branch_target  input  PC_W  branch destination address.
REQ-008 jump  input  1  unconditional jump request.
REQ-009 jump_target  input  PC_W  jump destination address.
REQ-010 stall  input  1  hold current PC this cycle.
REQ-011 halt_req  input  1  request to stop fetching.
REQ-012 pc  output  PC_W  current fetch address (register).
REQ-013 pc_next_seq  output  PC_W  combinational pc + INSTR_BYTES.
REQ-014 redirect  output  1  registered one-cycle pulse: pc was loaded from a branch or jump target at the previous edge.
REQ-015 halted  output  1  high while the FSM is in HALTED.

Function
REQ-016 The FSM SHALL have exactly two states, RUN and HALTED, and SHALL enter RUN on reset.
REQ-017 In RUN, the edge priority SHALL be: halt_req > stall > jump > take_branch > sequential.
REQ-018 Under halt_req in RUN, the FSM SHALL go to HALTED and hold pc.
REQ-019 Under stall without halt_req, the block SHALL hold pc and clear redirect, and SHALL drop any jump or take_branch presented that cycle.
REQ-020 Under jump, pc SHALL load jump_target with its low log2(INSTR_BYTES) bits forced to 0, and redirect SHALL be 1 next cycle.
REQ-021 Under take_branch without jump, pc SHALL load branch_target aligned the same way, and redirect SHALL be 1 next cycle.
REQ-022 Otherwise pc SHALL load pc_next_seq and redirect SHALL be 0.
REQ-023 pc_next_seq SHALL wrap modulo 2^PC_W, with no overflow flag.
REQ-024 Latency from a request input to pc update SHALL be one clock edge.
REQ-025 In HALTED, pc SHALL hold, redirect SHALL be 0, and all inputs except rst SHALL be ignored.
REQ-026 HALTED SHALL be left only via rst.
REQ-027 halted SHALL be a registered decode of state.

Reset
REQ-028 On rst, at the edge: pc = RESET_PC aligned, redirect = 0, halted = 0, state = RUN, branch_count = 0 if present.
REQ-029 rst SHALL override every other input in any state, including mid-stall and HALTED.

Configuration
REQ-030 With PC_BRANCH_CNT_EN defined, the block SHALL add output branch_count (32 bits), which increments at each edge where a take_branch redirect is applied and saturates at 32'hFFFF_FFFF.
REQ-031 Without PC_BRANCH_CNT_EN, the port and counter logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package pc_pkg SHALL hold the FSM state enum (RUN, HALTED) and the INSTR_BYTES default constant.
REQ-033 One sub-module, pc_next_sel (pure combinational priority mux producing the next pc and the redirect flag), SHALL be instantiated; the registers and FSM SHALL reside in pc_unit.

Verification
REQ-034 Reset then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC; redirect = 0 throughout.
REQ-035 At pc = 0x10, take_branch = 1 with branch_target = 0x103 -> next pc = 0x100, redirect = 1 for one cycle, then pc = 0x104.
REQ-036 Same cycle: jump = 1 with jump_target = 0x200, and take_branch = 1 with branch_target = 0x300 -> pc = 0x200.
REQ-037 Same cycle: stall = 1 and jump = 1 at pc = 0x20 -> pc stays 0x20, redirect = 0; the next idle cycle gives pc = 0x24.
REQ-038 pc = 0xFFFF_FFFC, idle -> pc = 0x0; then halt_req -> halted = 1 and pc frozen for 5 cycles with jump toggling; then rst -> pc = 0x0, halted = 0.
REQ-039 With PC_BRANCH_CNT_EN defined, 3 taken branches with one stalled -> branch_count = 2.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and
// the default sequential fetch increment.
package pc_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

  localparam int unsigned INSTR_BYTES_DEF = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage (purely combinational).
// Priority: halt_req > stall > jump > take_branch > sequential.
// Redirect targets have their sub-instruction offset bits cleared.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] pc_seq_i,
  input  logic            halt_req_i,
  input  logic            stall_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            take_branch_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            redirect_o
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(INSTR_BYTES - 1));

  // Select the next fetch address by fixed priority.
  always_comb begin
    pc_o       = pc_seq_i;
    redirect_o = 1'b0;
    if (halt_req_i || stall_i) begin
      pc_o = pc_i;
    end else if (jump_i) begin
      pc_o       = jump_target_i & ALIGN_MASK;
      redirect_o = 1'b1;
    end else if (take_branch_i) begin
      pc_o       = branch_target_i & ALIGN_MASK;
      redirect_o = 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, RUN/HALTED FSM and redirect pulse.
// Optional feature macro: PC_BRANCH_CNT_EN adds a saturating 32-bit
// branch_count output counting applied taken-branch redirects.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            take_branch,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            stall,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next_seq,
  output logic            redirect,
  output logic            halted
`ifdef PC_BRANCH_CNT_EN
  ,
  output logic [31:0]     branch_count
`endif
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(INSTR_BYTES - 1));

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirect_q, redirect_d;
  logic            halted_q;
  logic [PC_W-1:0] sel_pc;
  logic            sel_redirect;

  assign pc_next_seq = pc_q + PC_W'(INSTR_BYTES);
  assign pc          = pc_q;
  assign redirect    = redirect_q;
  assign halted      = halted_q;

  pc_next_sel #(
    .PC_W        (PC_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .pc_i            (pc_q),
    .pc_seq_i        (pc_next_seq),
    .halt_req_i      (halt_req),
    .stall_i         (stall),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .take_branch_i   (take_branch),
    .branch_target_i (branch_target),
    .pc_o            (sel_pc),
    .redirect_o      (sel_redirect)
  );

  // FSM next state and next PC; HALTED ignores every request input.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (state_q == RUN) begin
      if (halt_req) begin
        state_d = HALTED;
      end
      pc_d       = sel_pc;
      redirect_d = sel_redirect;
    end
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC & ALIGN_MASK;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      halted_q   <= (state_d == HALTED);
    end
  end

`ifdef PC_BRANCH_CNT_EN
  logic [31:0] cnt_q;
  logic        br_apply;

  // A redirect that is not a jump can only come from take_branch.
  assign br_apply     = (state_q == RUN) && sel_redirect && !jump;
  assign branch_count = cnt_q;

  // Saturating count of applied taken-branch redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (br_apply && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`endif

endmodule
